// File: rtl/ysyx_040750_csr_regfile_pkg.sv
// Shared CSR definitions: addresses, mstatus field positions and masks, cause codes.
// The decoder and the forwarder import this package as well.
package ysyx_040750_csr_regfile_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;

    // Only MIE and MPIE are stored; MPP is hard-wired to machine mode on read.
    localparam logic [63:0] MSTATUS_WMASK  = 64'h0000_0000_0000_0088;
    localparam logic [63:0] MSTATUS_MPP_RO = 64'h0000_0000_0000_1800;
    localparam logic [63:0] MCAUSE_ECALL_M = 64'd11;

    function automatic logic csr_implemented(input logic [11:0] addr);
        logic hit;
        hit = 1'b0;
        case (addr)
            CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
            CSR_MEPC, CSR_MCAUSE, CSR_MIP, CSR_MCYCLE: hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/ysyx_040750_csr_trap_ctrl.sv
// Trap/return sequencing: resolves ecall vs mret, computes mstatus/mepc/mcause next state
// (trap updates override WB writes to those CSRs) and registers the fetch redirect.
module ysyx_040750_csr_trap_ctrl
    import ysyx_040750_csr_regfile_pkg::*;
#(
    parameter int              XLEN         = 64,
    parameter logic [XLEN-1:0] MCAUSE_ECALL = XLEN'(MCAUSE_ECALL_M)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ecall,
    input  logic            mret,
    input  logic            csr_wen,
    input  logic [11:0]     csr_waddr,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic [XLEN-1:0] pc_wb,
    input  logic [XLEN-1:0] mstatus,
    input  logic [XLEN-1:0] mepc,
    input  logic [XLEN-1:0] mcause,
    input  logic [XLEN-1:0] mtvec,
    output logic [XLEN-1:0] mstatus_next,
    output logic [XLEN-1:0] mepc_next,
    output logic [XLEN-1:0] mcause_next,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic            take_ecall;
    logic            take_mret;
    logic            redirect_reg;
    logic            redirect_next;
    logic [XLEN-1:0] redirect_pc_reg;
    logic [XLEN-1:0] redirect_pc_next;

    always_comb begin
        take_ecall       = ecall;
        take_mret        = mret & ~ecall;
        mstatus_next     = mstatus;
        mepc_next        = mepc;
        mcause_next      = mcause;
        redirect_next    = take_ecall | take_mret;
        redirect_pc_next = '0;

        if (csr_wen && csr_waddr == CSR_MSTATUS) mstatus_next = csr_wdata & XLEN'(MSTATUS_WMASK);
        if (csr_wen && csr_waddr == CSR_MEPC)    mepc_next    = csr_wdata & ALIGN_MASK;
        if (csr_wen && csr_waddr == CSR_MCAUSE)  mcause_next  = csr_wdata;

        // Trap fields are rebuilt from pre-edge state so a same-cycle write is discarded.
        if (take_ecall) begin
            mstatus_next               = mstatus;
            mstatus_next[MSTATUS_MPIE] = mstatus[MSTATUS_MIE];
            mstatus_next[MSTATUS_MIE]  = 1'b0;
            mepc_next                  = pc_wb & ALIGN_MASK;
            mcause_next                = MCAUSE_ECALL;
            redirect_pc_next           = mtvec & ALIGN_MASK;
        end else if (take_mret) begin
            mstatus_next               = mstatus;
            mstatus_next[MSTATUS_MIE]  = mstatus[MSTATUS_MPIE];
            mstatus_next[MSTATUS_MPIE] = 1'b1;
            redirect_pc_next           = mepc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_reg    <= 1'b0;
            redirect_pc_reg <= '0;
        end else begin
            redirect_reg    <= redirect_next;
            redirect_pc_reg <= redirect_pc_next;
        end
    end

    assign redirect    = redirect_reg;
    assign redirect_pc = redirect_pc_reg;

endmodule

// File: rtl/ysyx_040750_csr_regfile.sv
// Machine-mode CSR register file: combinational read port for ID, synchronous write port
// and trap/return events from WB, free-running mcycle, registered fetch redirect.
module ysyx_040750_csr_regfile
    import ysyx_040750_csr_regfile_pkg::*;
#(
    parameter int              XLEN         = 64,
    parameter logic [XLEN-1:0] MTVEC_RST    = '0,
    parameter logic [XLEN-1:0] MCAUSE_ECALL = XLEN'(11)
) (
    input  logic            I_sys_clk,
    input  logic            I_rst,
    input  logic [11:0]     I_csr_raddr,
    output logic [XLEN-1:0] O_csr_rdata,
    output logic            O_csr_illegal,
    input  logic            I_csr_wen,
    input  logic [11:0]     I_csr_waddr,
    input  logic [XLEN-1:0] I_csr_wdata,
    input  logic            I_ecall,
    input  logic            I_mret,
    input  logic [XLEN-1:0] I_pc_WB,
    output logic            O_redirect,
    output logic [XLEN-1:0] O_redirect_pc
);

    logic [XLEN-1:0] mstatus_reg, mstatus_next;
    logic [XLEN-1:0] mepc_reg, mepc_next;
    logic [XLEN-1:0] mcause_reg, mcause_next;
    logic [XLEN-1:0] mie_reg, mtvec_reg, mscratch_reg, mcycle_reg;

    ysyx_040750_csr_trap_ctrl #(
        .XLEN         (XLEN),
        .MCAUSE_ECALL (MCAUSE_ECALL)
    ) u_trap_ctrl (
        .clk          (I_sys_clk),
        .rst          (I_rst),
        .ecall        (I_ecall),
        .mret         (I_mret),
        .csr_wen      (I_csr_wen),
        .csr_waddr    (I_csr_waddr),
        .csr_wdata    (I_csr_wdata),
        .pc_wb        (I_pc_WB),
        .mstatus      (mstatus_reg),
        .mepc         (mepc_reg),
        .mcause       (mcause_reg),
        .mtvec        (mtvec_reg),
        .mstatus_next (mstatus_next),
        .mepc_next    (mepc_next),
        .mcause_next  (mcause_next),
        .redirect     (O_redirect),
        .redirect_pc  (O_redirect_pc)
    );

    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst) begin
            mstatus_reg  <= '0;
            mepc_reg     <= '0;
            mcause_reg   <= '0;
            mie_reg      <= '0;
            mtvec_reg    <= MTVEC_RST;
            mscratch_reg <= '0;
            mcycle_reg   <= '0;
        end else begin
            mstatus_reg <= mstatus_next;
            mepc_reg    <= mepc_next;
            mcause_reg  <= mcause_next;
            if (I_csr_wen && I_csr_waddr == CSR_MIE)      mie_reg      <= I_csr_wdata;
            if (I_csr_wen && I_csr_waddr == CSR_MTVEC)    mtvec_reg    <= I_csr_wdata;
            if (I_csr_wen && I_csr_waddr == CSR_MSCRATCH) mscratch_reg <= I_csr_wdata;
            // A software write to mcycle replaces that edge's increment.
            if (I_csr_wen && I_csr_waddr == CSR_MCYCLE)   mcycle_reg   <= I_csr_wdata;
            else                                          mcycle_reg   <= mcycle_reg + XLEN'(1);
        end
    end

    always_comb begin
        O_csr_rdata   = '0;
        O_csr_illegal = ~csr_implemented(I_csr_raddr);
        case (I_csr_raddr)
            CSR_MSTATUS:  O_csr_rdata = (mstatus_reg & XLEN'(MSTATUS_WMASK)) | XLEN'(MSTATUS_MPP_RO);
            CSR_MIE:      O_csr_rdata = mie_reg;
            CSR_MTVEC:    O_csr_rdata = mtvec_reg;
            CSR_MSCRATCH: O_csr_rdata = mscratch_reg;
            CSR_MEPC:     O_csr_rdata = mepc_reg;
            CSR_MCAUSE:   O_csr_rdata = mcause_reg;
            CSR_MCYCLE:   O_csr_rdata = mcycle_reg;
            default:      O_csr_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_ysyx_040750_csr_regfile.sv
// Self-checking bench for the CSR register file: vector table for reads/writes/traps,
// scoreboard queue for redirect pulses, hand sequences for reset, mcycle wrap and async reset.
module tb_ysyx_040750_csr_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] raddr = '0;
    logic [63:0] rdata;
    logic        illegal;
    logic        wen = 1'b0;
    logic [11:0] waddr = '0;
    logic [63:0] wdata = '0;
    logic        ecall = 1'b0;
    logic        mret = 1'b0;
    logic [63:0] pc_wb = '0;
    logic        redirect;
    logic [63:0] redirect_pc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ysyx_040750_csr_regfile dut (
        .I_sys_clk     (clk),
        .I_rst         (rst),
        .I_csr_raddr   (raddr),
        .O_csr_rdata   (rdata),
        .O_csr_illegal (illegal),
        .I_csr_wen     (wen),
        .I_csr_waddr   (waddr),
        .I_csr_wdata   (wdata),
        .I_ecall       (ecall),
        .I_mret        (mret),
        .I_pc_WB       (pc_wb),
        .O_redirect    (redirect),
        .O_redirect_pc (redirect_pc)
    );

    typedef struct {
        logic        wen;
        logic [11:0] waddr;
        logic [63:0] wdata;
        logic        ecall;
        logic        mret;
        logic [63:0] pc;
        logic [11:0] raddr;
        logic [63:0] exp_rdata;
        logic        exp_illegal;
        logic        exp_redir;
        logic [63:0] exp_rpc;
    } vec_t;

    typedef struct {
        logic        redir;
        logic [63:0] rpc;
        int          idx;
    } redir_t;

    vec_t   vecs[$];
    redir_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [11:0] wa, input logic [63:0] wd,
                                input logic ec, input logic mr, input logic [63:0] pc,
                                input logic [11:0] ra, input logic [63:0] er, input logic ei,
                                input logic ed, input logic [63:0] epc);
        vec_t v;
        v.wen = w; v.waddr = wa; v.wdata = wd; v.ecall = ec; v.mret = mr; v.pc = pc;
        v.raddr = ra; v.exp_rdata = er; v.exp_illegal = ei; v.exp_redir = ed; v.exp_rpc = epc;
        return v;
    endfunction

    task automatic apply(input vec_t v, input int idx);
        redir_t e;
        redir_t got;
        @(negedge clk);
        wen = v.wen; waddr = v.waddr; wdata = v.wdata;
        ecall = v.ecall; mret = v.mret; pc_wb = v.pc; raddr = v.raddr;
        #1;
        check($sformatf("v%0d rdata", idx), rdata, v.exp_rdata);
        check($sformatf("v%0d illegal", idx), {63'd0, illegal}, {63'd0, v.exp_illegal});
        e.redir = v.exp_redir; e.rpc = v.exp_rpc; e.idx = idx;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check($sformatf("v%0d redirect", got.idx), {63'd0, redirect}, {63'd0, got.redir});
        if (got.redir) check($sformatf("v%0d redirect_pc", got.idx), redirect_pc, got.rpc);
        $display("vec %0d raddr=%h rdata=%h redirect=%b pc=%h", idx, v.raddr, rdata, redirect, redirect_pc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #2;
        check("reset redirect", {63'd0, redirect}, 64'd0);
        check("reset redirect_pc", redirect_pc, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        raddr = 12'h300; #1; check("reset mstatus", rdata, 64'h1800);
        raddr = 12'h305; #1; check("reset mtvec", rdata, 64'h0);
        raddr = 12'hB00; #1; check("mcycle 0", rdata, 64'd0);
        @(negedge clk); #1; check("mcycle 1", rdata, 64'd1);
        @(negedge clk); #1; check("mcycle 2", rdata, 64'd2);
        $display("reset sequence done");

        //               wen  waddr   wdata                  ec    mr    pc               raddr   exp_rdata              ill   red   rpc
        vecs.push_back(mk(1, 12'h305, 64'h8000_0103,         0, 0, 64'h0,           12'h305, 64'h0,                 0, 0, 64'h0));
        vecs.push_back(mk(0, 12'h000, 64'h0,                 0, 0, 64'h0,           12'h305, 64'h8000_0103,         0, 0, 64'h0));
        vecs.push_back(mk(1, 12'h305, 64'h8000_0100,         0, 0, 64'h0,           12'h305, 64'h8000_0103,         0, 0, 64'h0));
        vecs.push_back(mk(1, 12'h300, 64'h8,                 0, 0, 64'h0,           12'h300, 64'h1800,              0, 0, 64'h0));
        vecs.push_back(mk(0, 12'h000, 64'h0,                 1, 0, 64'h8000_0040,   12'h300, 64'h1808,              0, 1, 64'h8000_0100));
        vecs.push_back(mk(0, 12'h000, 64'h0,                 0, 0, 64'h0,           12'h341, 64'h8000_0040,         0, 0, 64'h0));
        vecs.push_back(mk(0, 12'h000, 64'h0,                 0, 0, 64'h0,           12'h342, 64'd11,                0, 0, 64'h0));
        vecs.push_back(mk(0, 12'h000, 64'h0,                 0, 0, 64'h0,           12'h300, 64'h1880,              0, 0, 64'h0));
        vecs.push_back(mk(0, 12'h000, 64'h0,                 0, 1, 64'h0,           12'h300, 64'h1880,              0, 1, 64'h8000_0040));
        vecs.push_back(mk(0, 12'h000, 64'h0,                 0, 0, 64'h0,           12'h300, 64'h1888,              0, 0, 64'h0));
        vecs.push_back(mk(1, 12'h300, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 64'h0,         12'h300, 64'h1888,              0, 0, 64'h0));
        vecs.push_back(mk(0, 12'h000, 64'h0,                 0, 0, 64'h0,           12'h300, 64'h1888,              0, 0, 64'h0));
        vecs.push_back(mk(1, 12'h342, 64'h5,                 1, 0, 64'h8000_0044,   12'h342, 64'd11,                0, 1, 64'h8000_0100));
        vecs.push_back(mk(0, 12'h000, 64'h0,                 0, 0, 64'h0,           12'h342, 64'd11,                0, 0, 64'h0));
        vecs.push_back(mk(0, 12'h000, 64'h0,                 0, 0, 64'h0,           12'h300, 64'h1880,              0, 0, 64'h0));
        vecs.push_back(mk(1, 12'h7C0, 64'h1234,              0, 0, 64'h0,           12'h7C0, 64'h0,                 1, 0, 64'h0));
        vecs.push_back(mk(1, 12'h344, 64'hFFFF,              0, 0, 64'h0,           12'h344, 64'h0,                 0, 0, 64'h0));
        vecs.push_back(mk(0, 12'h000, 64'h0,                 0, 0, 64'h0,           12'h344, 64'h0,                 0, 0, 64'h0));
        vecs.push_back(mk(1, 12'h341, 64'h8000_0203,         0, 0, 64'h0,           12'h340, 64'h0,                 0, 0, 64'h0));
        vecs.push_back(mk(0, 12'h000, 64'h0,                 0, 0, 64'h0,           12'h341, 64'h8000_0200,         0, 0, 64'h0));
        vecs.push_back(mk(1, 12'h340, 64'hDEAD_BEEF,         0, 1, 64'h0,           12'h340, 64'h0,                 0, 1, 64'h8000_0200));
        vecs.push_back(mk(0, 12'h000, 64'h0,                 0, 0, 64'h0,           12'h340, 64'hDEAD_BEEF,         0, 0, 64'h0));
        vecs.push_back(mk(0, 12'h000, 64'h0,                 1, 1, 64'h8000_0100,   12'h300, 64'h1888,              0, 1, 64'h8000_0100));
        vecs.push_back(mk(0, 12'h000, 64'h0,                 0, 1, 64'h0,           12'h300, 64'h1880,              0, 1, 64'h8000_0100));
        vecs.push_back(mk(1, 12'h304, 64'h888,               0, 0, 64'h0,           12'h300, 64'h1888,              0, 0, 64'h0));
        vecs.push_back(mk(0, 12'h000, 64'h0,                 0, 0, 64'h0,           12'h304, 64'h888,               0, 0, 64'h0));
        vecs.push_back(mk(1, 12'h300, 64'h0,                 1, 0, 64'h8000_0010,   12'h300, 64'h1888,              0, 1, 64'h8000_0100));
        vecs.push_back(mk(0, 12'h000, 64'h0,                 0, 0, 64'h0,           12'h300, 64'h1880,              0, 0, 64'h0));
        vecs.push_back(mk(0, 12'h000, 64'h0,                 0, 0, 64'h0,           12'h341, 64'h8000_0010,         0, 0, 64'h0));

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);
        check("scoreboard empty", 64'(sb.size()), 64'd0);

        // mcycle write wins over increment, then wraps to zero
        @(negedge clk);
        wen = 1'b1; waddr = 12'hB00; wdata = 64'hFFFF_FFFF_FFFF_FFFF; raddr = 12'hB00;
        @(posedge clk); #1;
        wen = 1'b0;
        check("mcycle written", rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge clk); #1;
        check("mcycle wrap", rdata, 64'd0);
        $display("mcycle wrap rdata=%h", rdata);

        // Async reset while a redirect pulse is active
        @(negedge clk);
        ecall = 1'b1; pc_wb = 64'h8000_0080;
        @(posedge clk); #1;
        ecall = 1'b0;
        check("pre-reset redirect", {63'd0, redirect}, 64'd1);
        #1 rst = 1'b1;
        #1;
        check("async reset redirect", {63'd0, redirect}, 64'd0);
        check("async reset redirect_pc", redirect_pc, 64'd0);
        raddr = 12'h341; #1; check("async reset mepc", rdata, 64'd0);
        raddr = 12'h300; #1; check("async reset mstatus", rdata, 64'h1800);
        @(negedge clk);
        rst = 1'b0;
        $display("async reset sequence done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
